// File: rtl/fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_pkg : shared types and constants for parity_push_encoder      |
// | Rev 1.0  : initial release                                         |
// +--------------------------------------------------------------------+
package fifo_pkg;

    localparam int unsigned c_cnt_width = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage
`default_nettype wire

// File: rtl/parity_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | parity_gen : combinational payload + parity word builder           |
// | Rev 1.0    : initial release                                       |
// +--------------------------------------------------------------------+
module parity_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int EVEN_ODD   = 0,
    parameter int PARITY_BIT = 0
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  corrupt,
    output logic [DATA_WIDTH:0]   word
);

    localparam logic c_odd = (EVEN_ODD != 0);

    logic w_parity;

    // Even parity bit equals the payload XOR; odd flips it; corrupt flips again.
    assign w_parity = (^data) ^ c_odd ^ corrupt;

    generate
        if (PARITY_BIT == 0) begin : g_parity_lsb
            assign word = {data, w_parity};
        end else begin : g_parity_msb
            assign word = {w_parity, data};
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/parity_push_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | parity_push_encoder : parity encoder with two-entry skid buffer    |
// | Rev 1.0             : initial release                              |
// +--------------------------------------------------------------------+
module parity_push_encoder
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int EVEN_ODD   = 0,
    parameter int PARITY_BIT = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  in_data_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic                   corrupt_i,
    output logic [DATA_WIDTH:0]    push_data_o,
    output logic                   push_valid_o,
    input  logic                   push_grant_i,
    output logic [c_cnt_width-1:0] sent_count_o,
    output logic [c_cnt_width-1:0] corrupt_count_o
);

    localparam int unsigned c_word_w = DATA_WIDTH + 1;

    skid_state_t              r_state;
    skid_state_t              w_state_nxt;
    logic [c_word_w-1:0]      r_out_data;
    logic                     r_out_corrupt;
    logic [c_word_w-1:0]      r_skid_data;
    logic                     r_skid_corrupt;
    logic                     r_in_ready;
    logic [c_cnt_width-1:0]   r_sent_cnt;
    logic [c_cnt_width-1:0]   r_corrupt_cnt;
    logic [c_word_w-1:0]      w_enc_data;
    logic                     w_in_fire;
    logic                     w_out_fire;
    logic                     w_push_valid;

    parity_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .EVEN_ODD   (EVEN_ODD),
        .PARITY_BIT (PARITY_BIT)
    ) u_parity_gen (
        .data    (in_data_i),
        .corrupt (corrupt_i),
        .word    (w_enc_data)
    );

    assign w_push_valid = (r_state != EMPTY);
    assign w_in_fire    = in_valid_i & r_in_ready;
    assign w_out_fire   = w_push_valid & push_grant_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: if (w_in_fire) w_state_nxt = BUSY;
            BUSY: begin
                if (w_in_fire && !w_out_fire)      w_state_nxt = FULL;
                else if (!w_in_fire && w_out_fire) w_state_nxt = EMPTY;
            end
            FULL:  if (w_out_fire) w_state_nxt = BUSY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= EMPTY;
            r_out_data     <= '0;
            r_out_corrupt  <= 1'b0;
            r_skid_data    <= '0;
            r_skid_corrupt <= 1'b0;
            r_in_ready     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            // Registered ready looks ahead at the next state so it never accepts into FULL.
            r_in_ready <= (w_state_nxt != FULL);
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        r_out_data    <= w_enc_data;
                        r_out_corrupt <= corrupt_i;
                    end
                end
                BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        r_out_data    <= w_enc_data;
                        r_out_corrupt <= corrupt_i;
                    end else if (w_in_fire) begin
                        r_skid_data    <= w_enc_data;
                        r_skid_corrupt <= corrupt_i;
                    end
                end
                FULL: begin
                    if (w_out_fire) begin
                        r_out_data    <= r_skid_data;
                        r_out_corrupt <= r_skid_corrupt;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sent_cnt    <= '0;
            r_corrupt_cnt <= '0;
        end else if (w_out_fire) begin
            if (r_sent_cnt != '1) begin
                r_sent_cnt <= r_sent_cnt + 1'b1;
            end
            if (r_out_corrupt && (r_corrupt_cnt != '1)) begin
                r_corrupt_cnt <= r_corrupt_cnt + 1'b1;
            end
        end
    end

    assign in_ready_o      = r_in_ready;
    assign push_data_o     = r_out_data;
    assign push_valid_o    = w_push_valid;
    assign sent_count_o    = r_sent_cnt;
    assign corrupt_count_o = r_corrupt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_parity_push_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_parity_push_encoder : scoreboard bench for parity_push_encoder  |
// | Rev 1.0                : initial release                           |
// +--------------------------------------------------------------------+
module tb_parity_push_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        corrupt = 1'b0;
    logic [32:0] push_data;
    logic        push_valid;
    logic        push_grant = 1'b1;
    logic [15:0] sent_count;
    logic [15:0] corrupt_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [32:0] sb_q[$];

    always #5 clk = ~clk;

    parity_push_encoder #(
        .DATA_WIDTH (32),
        .EVEN_ODD   (0),
        .PARITY_BIT (0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_data_i       (in_data),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .corrupt_i       (corrupt),
        .push_data_o     (push_data),
        .push_valid_o    (push_valid),
        .push_grant_i    (push_grant),
        .sent_count_o    (sent_count),
        .corrupt_count_o (corrupt_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Independent reference: count ones, even parity, optional flip.
    function automatic logic [32:0] model_enc(input logic [31:0] d, input logic c);
        logic p;
        p = ($countones(d) % 2 == 1) ? 1'b1 : 1'b0;
        return {d, p ^ c};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (push_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_push", {63'b0, push_valid}, 64'd0);
                end else if (push_grant) begin
                    check("push_data", {31'b0, push_data}, {31'b0, sb_q.pop_front()});
                end else begin
                    check("hold_data", {31'b0, push_data}, {31'b0, sb_q[0]});
                end
            end
            if (in_valid && in_ready) sb_q.push_back(model_enc(in_data, corrupt));
        end
    end

    task automatic send(input logic [31:0] d, input logic c);
        int n = 0;
        in_data  = d;
        corrupt  = c;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("send_timeout", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        corrupt  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || push_valid) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) check("drain_timeout", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        corrupt  = 1'b0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb_q.delete();
        check("rst_push_data",  {31'b0, push_data}, 64'd0);
        check("rst_push_valid", {63'b0, push_valid}, 64'd0);
        check("rst_in_ready",   {63'b0, in_ready}, 64'd0);
        check("rst_sent",       {48'b0, sent_count}, 64'd0);
        check("rst_corrupt",    {48'b0, corrupt_count}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_before_edge", {63'b0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        check("ready_after_edge", {63'b0, in_ready}, 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset and encoding
        push_grant = 1'b1;
        do_reset();
        send(32'h3, 1'b0);
        check("enc_3", {31'b0, push_data}, 64'h6);
        send(32'h1, 1'b0);
        check("enc_1", {31'b0, push_data}, 64'h3);
        send(32'h3, 1'b1);
        check("enc_3_corrupt", {31'b0, push_data}, 64'h7);
        drain();
        check("enc_sent", {48'b0, sent_count}, 64'd3);
        check("enc_corrupt_cnt", {48'b0, corrupt_count}, 64'd1);

        // Backpressure
        do_reset();
        push_grant = 1'b0;
        send(32'hA, 1'b0);
        send(32'hB, 1'b0);
        check("bp_full_ready", {63'b0, in_ready}, 64'd0);
        check("bp_full_valid", {63'b0, push_valid}, 64'd1);
        check("bp_head", {31'b0, push_data}, 64'h14);
        fork
            send(32'hC, 1'b0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    #1;
                    check("bp_c_held", {63'b0, in_ready}, 64'd0);
                end
                @(posedge clk);
                #1;
                push_grant = 1'b1;
            end
        join
        drain();
        check("bp_sent", {48'b0, sent_count}, 64'd3);

        // Streaming with toggling grant
        do_reset();
        push_grant = 1'b1;
        fork
            for (int i = 0; i < 8; i++) send(32'h1000 + 32'(i * 7), (i % 3) == 0);
            begin
                repeat (24) begin
                    @(posedge clk);
                    #1;
                    push_grant = ~push_grant;
                end
            end
        join
        push_grant = 1'b1;
        drain();
        check("stream_sent", {48'b0, sent_count}, 64'd8);
        check("stream_corrupt", {48'b0, corrupt_count}, 64'd3);

        // Reset while FULL
        do_reset();
        push_grant = 1'b0;
        send(32'h11, 1'b0);
        send(32'h22, 1'b1);
        check("midfull_ready", {63'b0, in_ready}, 64'd0);
        #2;
        rst = 1'b1;
        #1;
        sb_q.delete();
        check("midrst_valid", {63'b0, push_valid}, 64'd0);
        check("midrst_data", {31'b0, push_data}, 64'd0);
        check("midrst_sent", {48'b0, sent_count}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        push_grant = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("midrst_no_push", {63'b0, push_valid}, 64'd0);
        check("midrst_sent_after", {48'b0, sent_count}, 64'd0);

        // Counter saturation
        do_reset();
        push_grant = 1'b1;
        for (int i = 0; i < 65540; i++) send(32'(i), i[0]);
        drain();
        check("sat_sent", {48'b0, sent_count}, 64'hFFFF);
        check("sat_corrupt", {48'b0, corrupt_count}, 64'd32770);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
